bitwise_arbiter: RTL and testbench
==================================

Name: bitwise_arbiter

Overview:
- Shares one `bitwise` datapath unit (ops MOV/XOR/ASL/SWP on R0–R3) between two independent requesters.
- Each requester posts an {op, in} command with a req/ack handshake.
- The arbiter picks requesters round-robin, drives the unit's s/op/in, waits for the unit's done, and returns the unit's out to the winning requester.
- A watchdog aborts a command whose done never arrives, so a hung unit cannot lock out the other requester.

Parameters:
- TIMEOUT, 64: maximum cycles spent waiting for the done handshake after issue before aborting; legal range 4..255.
- CW, 8: width of the watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 command valid; held high until ack0.
- op0  in  4  requester 0 opcode; stable while req0 is high.
- in0  in  8  requester 0 immediate; stable while req0 is high.
- ack0  out  1  one-cycle pulse: requester 0 command finished.
- rdata0  out  8  result for requester 0; valid on ack0 and held until the next ack0.
- err0  out  1  qualifies ack0: 1 means the command timed out.
- req1, op1, in1, ack1, rdata1, err1: identical set for requester 1.
- bw_s  out  1  start pulse to the bitwise unit.
- bw_op  out  4  opcode to the bitwise unit.
- bw_in  out  8  immediate to the bitwise unit.
- bw_out  in  8  result from the bitwise unit.
- bw_done  in  1  done level from the bitwise unit.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all ack/err/bw_s = 0; rdata0/rdata1/bw_op/bw_in = 0.
  - Round-robin pointer set so requester 0 wins the first tie.
  - Watchdog counter = 0.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both reqs: grant the requester that did not win last time.
  - On grant: register gnt, and latch op/in from the winner into bw_op/bw_in; go to ISSUE.
- ISSUE:
  - bw_s = 1 for exactly this one cycle; bw_op/bw_in are stable from ISSUE through RESP.
  - Watchdog cleared; go to WAIT_LO.
- WAIT_LO:
  - Waits for bw_done = 0. This discards a stale done left over from the unit's previous command.
  - bw_done = 0: go to WAIT_HI.
- WAIT_HI:
  - Waits for bw_done = 1. When it is seen, capture bw_out into rdata[gnt] and clear err[gnt]; go to RESP.
- Watchdog:
  - Increments every cycle in WAIT_LO and WAIT_HI.
  - If it reaches TIMEOUT before WAIT_HI completes: rdata[gnt] is unchanged, err[gnt] = 1, go to RESP.
- RESP:
  - ack[gnt] = 1 for one cycle.
  - Round-robin pointer updated to the other requester; go to IDLE.
- Latency: a single uncontended command acks min 4 cycles after req rises (IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP), plus the unit's own latency.
- Back-to-back:
  - A requester samples ack and drops req in the same cycle.
  - Because the arbiter is back in IDLE the cycle after RESP, the other pending requester is granted then.
  - No idle bubble is added beyond that one cycle.
- Request changes:
  - A req withdrawn before grant is simply ignored.
  - A req withdrawn after grant does not abort the command; ack is still pulsed.
  - op/in changing after grant have no effect.
- err is valid only while ack is high. rdata and err hold their values between acks.
- Reset mid-command: all state is dropped and no ack is produced. The unit's internal registers are not restored; that is the unit's own reset domain.
- bw_done high while in IDLE/ISSUE is ignored.

Decomposition:
- Shared package holds:
  - opcode constants OP_MOV_R0..R3 = 4'b0000..0011, OP_XOR = 4'b0100, OP_ASL = 4'b1000, OP_SWP_R1..R3 = 4'b1101..1111;
  - the arbiter state encoding.
- One natural sub-module: rr_arb2, a two-input round-robin arbiter holding the last-winner pointer. It is purely a grant decision plus pointer register, updated on an "accepted" strobe.

Test Plan:
- Req0 op=MOV_R1 in=42 alone, with a bitwise model asserting done 3 cycles after bw_s → exactly one bw_s; ack0 pulses once; err0 = 0; rdata0 = model out; ack1 never asserts.
- Req0 and req1 rise in the same cycle right after reset (MOV_R1 42, MOV_R2 11) → requester 0 serviced first, then requester 1; exactly two bw_s pulses total; each requester acks exactly once.
- Both requesters hold req continuously for 6 commands → grants strictly alternate 0,1,0,1,0,1; never two consecutive grants to the same side.
- Sequence MOV_R1 42, MOV_R2 11, XOR, ASL, SWP_R2 via requester 1 against the real bitwise unit → after the SWP ack, the unit's R0 = 11 and R2 = 64.
- bw_done stuck at 0 with TIMEOUT=16 → ack0 with err0 = 1 exactly 16 cycles after entering WAIT_LO; rdata0 unchanged; a queued req1 is then serviced normally.
- Reset driven low during WAIT_HI → busy = 0 and all acks = 0 immediately (asynchronously); next req0 after reset release completes normally.

Source files
------------

// File: rtl/bitwise_arbiter_pkg.sv
// Shared opcodes, command payload and arbiter state encoding for bitwise_arbiter.
package bitwise_arbiter_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [OP_W-1:0] OP_MOV_R0 = 4'b0000;
    localparam logic [OP_W-1:0] OP_MOV_R1 = 4'b0001;
    localparam logic [OP_W-1:0] OP_MOV_R2 = 4'b0010;
    localparam logic [OP_W-1:0] OP_MOV_R3 = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR    = 4'b0100;
    localparam logic [OP_W-1:0] OP_ASL    = 4'b1000;
    localparam logic [OP_W-1:0] OP_SWP_R1 = 4'b1101;
    localparam logic [OP_W-1:0] OP_SWP_R2 = 4'b1110;
    localparam logic [OP_W-1:0] OP_SWP_R3 = 4'b1111;

    // Command handed to the bitwise unit
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
    } bw_cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        RESP    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/bitwise_arbiter_rr_arb2.sv
// Two-input round-robin grant decision with a registered tie-break pointer.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    input  logic win,
    output logic gnt_c,
    output logic valid_c
);

    // Requester that wins the next tie
    logic prio_q;

    // Pointer moves away from the requester whose command was just accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~win;
        end
    end

    assign valid_c = req0 | req1;
    assign gnt_c   = (req0 & req1) ? prio_q : req1;

endmodule

// File: rtl/bitwise_arbiter.sv
// Shares one bitwise datapath unit between two req/ack requesters with a done watchdog.
module bitwise_arbiter
    import bitwise_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [3:0]  op0,
    input  logic [7:0]  in0,
    output logic        ack0,
    output logic [7:0]  rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic [3:0]  op1,
    input  logic [7:0]  in1,
    output logic        ack1,
    output logic [7:0]  rdata1,
    output logic        err1,
    output logic        bw_s,
    output logic [3:0]  bw_op,
    output logic [7:0]  bw_in,
    input  logic [7:0]  bw_out,
    input  logic        bw_done,
    output logic        busy
);

    arb_state_e  state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [CW-1:0] wdog_q, wdog_d, wdog_inc;
    bw_cmd_t     cmd_q, cmd_d;
    logic [7:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic        ack0_q, ack1_q, bw_s_q, busy_q;
    logic        arb_gnt, arb_valid, accept;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .accept  (accept),
        .win     (gnt_q),
        .gnt_c   (arb_gnt),
        .valid_c (arb_valid)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, grant latch, watchdog and result capture
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        wdog_d   = wdog_q;
        cmd_d    = cmd_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        accept   = 1'b0;
        wdog_inc = wdog_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d     = arb_gnt;
                    cmd_d.op  = arb_gnt ? op1 : op0;
                    cmd_d.imm = arb_gnt ? in1 : in0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                wdog_d = wdog_inc;
                if (wdog_inc == CW'(TIMEOUT)) begin
                    if (gnt_q) err1_d = 1'b1;
                    else       err0_d = 1'b1;
                    state_d = RESP;
                end else if (!bw_done) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                wdog_d = wdog_inc;
                if (bw_done) begin
                    if (gnt_q) begin
                        rdata1_d = bw_out;
                        err1_d   = 1'b0;
                    end else begin
                        rdata0_d = bw_out;
                        err0_d   = 1'b0;
                    end
                    state_d = RESP;
                end else if (wdog_inc == CW'(TIMEOUT)) begin
                    if (gnt_q) err1_d = 1'b1;
                    else       err0_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                accept  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q    <= 1'b0;
            wdog_q   <= '0;
            cmd_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            bw_s_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            gnt_q    <= gnt_d;
            wdog_q   <= wdog_d;
            cmd_q    <= cmd_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            ack0_q   <= (state_d == RESP) && !gnt_d;
            ack1_q   <= (state_d == RESP) && gnt_d;
            bw_s_q   <= (state_d == ISSUE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign bw_s   = bw_s_q;
    assign bw_op  = cmd_q.op;
    assign bw_in  = cmd_q.imm;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Directed bench for bitwise_arbiter with a behavioural bitwise unit model.
module tb_bitwise_arbiter;
    import bitwise_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] op0 = '0, op1 = '0;
    logic [7:0] in0 = '0, in1 = '0;
    logic       ack0, ack1, err0, err1, bw_s, bw_done, busy;
    logic [7:0] rdata0, rdata1, bw_in, bw_out;
    logic [3:0] bw_op;

    bitwise_arbiter #(.TIMEOUT(16), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .in0(in0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .op1(op1), .in1(in1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .bw_s(bw_s), .bw_op(bw_op), .bw_in(bw_in), .bw_out(bw_out), .bw_done(bw_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Bitwise unit model: done level drops on start, rises 3 cycles later
    logic [7:0] mr [4] = '{default: 8'h00};
    logic       m_done = 1'b0;
    logic [1:0] m_cnt = 2'd0;
    logic [7:0] m_out = 8'h00;
    logic       stuck = 1'b0;

    always @(posedge clk) begin
        if (bw_s) begin
            m_done <= 1'b0;
            m_cnt  <= 2'd3;
            if (bw_op[3:2] == 2'b00) begin
                mr[bw_op[1:0]] <= bw_in;
                m_out <= bw_in;
            end else if (bw_op == OP_XOR) begin
                mr[0] <= mr[1] ^ mr[2];
                m_out <= mr[1] ^ mr[2];
            end else if (bw_op == OP_ASL) begin
                mr[0] <= mr[0] << bw_in[2:0];
                m_out <= mr[0] << bw_in[2:0];
            end else if (bw_op[3:2] == 2'b11 && bw_op[1:0] != 2'b00) begin
                mr[0] <= mr[bw_op[1:0]];
                mr[bw_op[1:0]] <= mr[0];
                m_out <= mr[bw_op[1:0]];
            end else begin
                m_out <= 8'h00;
            end
        end else if (m_cnt != 2'd0) begin
            m_cnt <= m_cnt - 2'd1;
            if (m_cnt == 2'd1) m_done <= 1'b1;
        end
    end

    assign bw_done = m_done & ~stuck;
    assign bw_out  = m_out;

    // Cycle count and event monitor
    int cyc = 0;
    int nbws = 0, nack0 = 0, nack1 = 0, bws_cyc = 0;
    int gq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bw_s) begin
            nbws    <= nbws + 1;
            bws_cyc <= cyc;
        end
        if (ack0) begin
            nack0 <= nack0 + 1;
            gq.push_back(0);
        end
        if (ack1) begin
            nack1 <= nack1 + 1;
            gq.push_back(1);
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gq_at(input int i);
        if (i < gq.size()) return gq[i];
        return -1;
    endfunction

    // Raise req, wait (bounded) for ack, drop req in the ack cycle
    task automatic send(input int id, input logic [3:0] op, input logic [7:0] imm,
                        output logic [7:0] rd, output logic er, output logic got,
                        output int lat, output int acyc);
        got = 1'b0; lat = 0; rd = '0; er = 1'b0; acyc = 0;
        if (id == 0) begin op0 = op; in0 = imm; req0 = 1'b1; end
        else         begin op1 = op; in1 = imm; req1 = 1'b1; end
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (id == 0 && ack0) begin got = 1'b1; rd = rdata0; er = err0; acyc = cyc; end
            if (id == 1 && ack1) begin got = 1'b1; rd = rdata1; er = err1; acyc = cyc; end
        end
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic cmd_chk(input string tag, input int id, input logic [3:0] op,
                           input logic [7:0] imm, input logic [7:0] exp_rd, input logic exp_err);
        logic [7:0] rd;
        logic       er, got;
        int         lat, acyc;
        send(id, op, imm, rd, er, got, lat, acyc);
        check({tag, "_ack"}, 32'(got), 32'd1);
        check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        check({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL tb_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic       er, got, found;
        int         lat, acyc, b_bws, b_a0, b_a1, q0, t5_wait;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_err", 32'({err0, err1}), 32'd0);
        check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        check("rst_bw_s", 32'(bw_s), 32'd0);
        check("rst_bw_cmd", 32'({bw_op, bw_in}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single uncontended command
        b_bws = nbws; b_a0 = nack0; b_a1 = nack1;
        send(0, OP_MOV_R1, 8'd42, rd, er, got, lat, acyc);
        check("t1_ack", 32'(got), 32'd1);
        check("t1_rdata", 32'(rd), 32'd42);
        check("t1_err", 32'(er), 32'd0);
        check("t1_latency", 32'(lat), 32'd6);
        repeat (3) @(negedge clk);
        check("t1_nbws", 32'(nbws - b_bws), 32'd1);
        check("t1_nack0", 32'(nack0 - b_a0), 32'd1);
        check("t1_nack1", 32'(nack1 - b_a1), 32'd0);

        // Simultaneous requests right after reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        b_bws = nbws; b_a0 = nack0; b_a1 = nack1; q0 = gq.size();
        fork
            cmd_chk("t2_r0", 0, OP_MOV_R1, 8'd42, 8'd42, 1'b0);
            cmd_chk("t2_r1", 1, OP_MOV_R2, 8'd11, 8'd11, 1'b0);
        join
        repeat (2) @(negedge clk);
        check("t2_first", 32'(gq_at(q0)), 32'd0);
        check("t2_second", 32'(gq_at(q0 + 1)), 32'd1);
        check("t2_nbws", 32'(nbws - b_bws), 32'd2);
        check("t2_nack0", 32'(nack0 - b_a0), 32'd1);
        check("t2_nack1", 32'(nack1 - b_a1), 32'd1);

        // Continuous contention alternates grants
        q0 = gq.size();
        fork
            begin
                for (int k = 0; k < 3; k++)
                    cmd_chk("t3_r0", 0, OP_MOV_R3, 8'(10 + k), 8'(10 + k), 1'b0);
            end
            begin
                for (int k = 0; k < 3; k++)
                    cmd_chk("t3_r1", 1, OP_MOV_R3, 8'(20 + k), 8'(20 + k), 1'b0);
            end
        join
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_grant%0d", k), 32'(gq_at(q0 + k)), 32'(k % 2));

        // Operation sequence through requester 1
        cmd_chk("t4_mov1", 1, OP_MOV_R1, 8'd42, 8'd42, 1'b0);
        cmd_chk("t4_mov2", 1, OP_MOV_R2, 8'd11, 8'd11, 1'b0);
        cmd_chk("t4_xor", 1, OP_XOR, 8'd0, 8'd33, 1'b0);
        cmd_chk("t4_asl", 1, OP_ASL, 8'd6, 8'd64, 1'b0);
        cmd_chk("t4_swp", 1, OP_SWP_R2, 8'd0, 8'd11, 1'b0);
        check("t4_unit_r0", 32'(mr[0]), 32'd11);
        check("t4_unit_r2", 32'(mr[2]), 32'd64);

        // Watchdog abort with a queued second requester
        stuck = 1'b1;
        t5_wait = -1;
        fork
            begin
                send(0, OP_MOV_R0, 8'h77, rd, er, got, lat, acyc);
                t5_wait = acyc - (bws_cyc + 1);
                stuck = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                cmd_chk("t5_r1", 1, OP_MOV_R3, 8'd99, 8'd99, 1'b0);
            end
        join
        check("t5_ack", 32'(got), 32'd1);
        check("t5_err", 32'(er), 32'd1);
        check("t5_rdata_held", 32'(rd), 32'd12);
        check("t5_wait_cycles", 32'(t5_wait), 32'd16);

        // Asynchronous reset during WAIT_HI
        @(negedge clk);
        op0 = OP_MOV_R0; in0 = 8'h33; req0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bw_s) found = 1'b1;
        end
        check("t6_issue", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        check("t6_busy_before", 32'(busy), 32'd1);
        b_a0 = nack0;
        #1 reset = 1'b0;
        #1;
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_acks_async", 32'({ack0, ack1}), 32'd0);
        check("t6_bw_s_async", 32'(bw_s), 32'd0);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_no_ack", 32'(nack0 - b_a0), 32'd0);
        check("t6_rdata_rst", 32'(rdata0), 32'd0);
        cmd_chk("t6_after", 0, OP_MOV_R2, 8'h5A, 8'h5A, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
